// File: rtl/oh_gray_pkg.sv
// oh_gray_pkg
//   Shared constants and segment-geometry helpers for the pipelined
//   Gray-to-binary decoder.
//
//   The N-bit word is cut into S segments starting from the MSB. Every segment
//   is seg_width(N, S) = ceil(N/S) bits wide; the last one takes whatever is
//   left. For some (N, S) pairs the trailing segments come out empty; those
//   stages simply forward the word and the carry.
//
//   Functions:
//     seg_width(n, s)    - nominal segment width, ceil(n/s)
//     seg_hi(n, s, k)    - MSB index of segment k (negative when k is empty)
//     seg_lo(n, s, k)    - LSB index of segment k (clamped at 0)
//     seg_empty(n, s, k) - 1 when segment k holds no bits
package oh_gray_pkg;

    localparam int DefaultWidth  = 32;
    localparam int DefaultStages = 2;

    function automatic int seg_width(input int n, input int s);
        return (n + s - 1) / s;
    endfunction

    function automatic int seg_hi(input int n, input int s, input int k);
        return n - 1 - k * seg_width(n, s);
    endfunction

    function automatic int seg_lo(input int n, input int s, input int k);
        int lo;
        lo = n - (k + 1) * seg_width(n, s);
        return (lo < 0) ? 0 : lo;
    endfunction

    function automatic bit seg_empty(input int n, input int s, input int k);
        return seg_hi(n, s, k) < seg_lo(n, s, k);
    endfunction

endpackage

// File: rtl/oh_gray2bin_stage.sv
// oh_gray2bin_stage
//   One pipeline stage of the Gray-to-binary decoder. Stage K resolves the
//   bits of segment K of the word it receives. The segments above it were
//   already resolved by earlier stages; the segments below are still Gray.
//   Decoding runs MSB first: b[i] = g[i] ^ b[i+1]. The bit above the segment
//   comes in as prev_carry, which is the resolved LSB of segment K-1 (0 for
//   stage 0).
//
//   Parameters:
//     N - word width, S - number of stages, K - index of this stage
//
//   Ports:
//     clk        - clock, rising edge
//     reset      - synchronous active-high reset, clears all held state
//     load       - stage may capture this cycle (empty or being drained)
//     prev_valid - word present on the prev_* inputs
//     prev_data  - word with segments 0..K-1 resolved
//     prev_carry - resolved LSB of segment K-1
//     prev_err   - step error tag travelling with prev_data
//     valid      - this stage holds a word
//     data       - held word, segments 0..K resolved
//     carry      - resolved LSB of segment K, for stage K+1
//     err        - held step error tag
module oh_gray2bin_stage
    import oh_gray_pkg::*;
#(
    parameter int N = DefaultWidth,
    parameter int S = DefaultStages,
    parameter int K = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         prev_valid,
    input  logic [N-1:0] prev_data,
    input  logic         prev_carry,
    input  logic         prev_err,
    output logic         valid,
    output logic [N-1:0] data,
    output logic         carry,
    output logic         err
);

    localparam int Hi = seg_hi(N, S, K);
    localparam int Lo = seg_lo(N, S, K);

    logic         valid_q;
    logic [N-1:0] data_q;
    logic         carry_q;
    logic         err_q;

    logic [N-1:0] resolved;
    logic         run;

    // Ripple the prefix XOR down through this segment only. For an empty
    // segment nothing matches, so the word and the carry pass through.
    always_comb begin
        resolved = prev_data;
        run      = prev_carry;
        for (int i = N - 1; i >= 0; i--) begin
            if (i <= Hi && i >= Lo) begin
                resolved[i] = prev_data[i] ^ run;
                run         = resolved[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (load) begin
            valid_q <= prev_valid;
            // Payload only moves with a real word, so a bubble never disturbs it.
            if (prev_valid) begin
                data_q  <= resolved;
                carry_q <= run;
                err_q   <= prev_err;
            end
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign carry = carry_q;
    assign err   = err_q;

endmodule

// File: rtl/oh_gray2bin_pipe.sv
// oh_gray2bin_pipe
//   Pipelined Gray-to-binary decoder with valid/ready handshakes on both
//   sides: out_bin[i] = ^in_gray[N-1:i]. There are S stages. Each stage
//   resolves one MSB-first segment. The latency is S cycles, and the pipe
//   moves one word per cycle while out_ready stays high.
//
//   Optional feature (macro OH_GRAY2BIN_STEPCHK_EN):
//     Gray step checker. A word whose in_gray differs from the previously
//     accepted in_gray in more than one bit is tagged with out_err=1. When the
//     macro is undefined, out_err is tied low and no history is kept.
//
//   Parameters:
//     N - data width (N >= 2), S - pipeline stages (1 <= S <= N)
//
//   Ports:
//     clk       - sole clock, rising edge
//     reset     - synchronous active-high reset
//     in_valid  - input word present
//     in_gray   - Gray-encoded input word
//     in_ready  - block accepts input this cycle (low while reset is high)
//     out_valid - output word present
//     out_bin   - binary-decoded output word
//     out_err   - step error tag travelling with out_bin
//     out_ready - downstream accepts output this cycle
module oh_gray2bin_pipe
    import oh_gray_pkg::*;
#(
    parameter int N = DefaultWidth,
    parameter int S = DefaultStages
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [N-1:0] in_gray,
    output logic         in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_bin,
    output logic         out_err,
    input  logic         out_ready
);

    if (N < 2) begin : g_bad_width
        $error("oh_gray2bin_pipe: N must be at least 2");
    end
    if (S < 1 || S > N) begin : g_bad_stages
        $error("oh_gray2bin_pipe: S must lie in 1..N");
    end

    // Index 0 is the input port; index k+1 is the output of stage k.
    logic         stg_valid [S+1];
    logic [N-1:0] stg_data  [S+1];
    logic         stg_carry [S+1];
    logic         stg_err   [S+1];

    // load[k] = stage k may capture this cycle; load[S] is the output transfer.
    logic [S:0]   load;
    logic         step_err;
    logic         unused_carry;

    // Backward ready chain: a stage can load if it is empty or its
    // successor loads. A hole anywhere downstream lets the stages
    // behind it advance.
    always_comb begin
        load    = '0;
        load[S] = out_ready;
        for (int k = S - 1; k >= 0; k--) begin
            load[k] = !stg_valid[k+1] || load[k+1];
        end
    end

    assign in_ready = load[0] && !reset;

    assign stg_valid[0] = in_valid;
    assign stg_data[0]  = in_gray;
    assign stg_carry[0] = 1'b0;
    assign stg_err[0]   = step_err;

    for (genvar k = 0; k < S; k++) begin : g_stage
        oh_gray2bin_stage #(
            .N (N),
            .S (S),
            .K (k)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .load       (load[k]),
            .prev_valid (stg_valid[k]),
            .prev_data  (stg_data[k]),
            .prev_carry (stg_carry[k]),
            .prev_err   (stg_err[k]),
            .valid      (stg_valid[k+1]),
            .data       (stg_data[k+1]),
            .carry      (stg_carry[k+1]),
            .err        (stg_err[k+1])
        );
    end

    // Nothing follows the last stage, so its carry has no consumer.
    assign unused_carry = stg_carry[S];

`ifdef OH_GRAY2BIN_STEPCHK_EN
    logic [N-1:0] hist_q;
    logic         hist_valid_q;
    logic [N-1:0] diff;

    assign diff = in_gray ^ hist_q;
    // diff & (diff - 1) clears the lowest set bit, so any bit left over means
    // at least two bits changed.
    assign step_err = hist_valid_q && (|(diff & (diff - {{(N-1){1'b0}}, 1'b1})));

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q       <= '0;
            hist_valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            hist_q       <= in_gray;
            hist_valid_q <= 1'b1;
        end
    end
`else
    assign step_err = 1'b0;
`endif

    assign out_valid = stg_valid[S];
    assign out_bin   = stg_data[S];
    assign out_err   = stg_err[S];

endmodule

// File: tb/tb_oh_gray2bin_pipe.sv
// tb_oh_gray2bin_pipe
//   Self-checking bench for oh_gray2bin_pipe. There are two instances:
//   N=4/S=2 for the directed and table-driven cases, and N=7/S=3 for a
//   random stream with random backpressure. Expected words go into a queue
//   at each input handshake and are compared at each output handshake.
//   Inputs are driven 1 time unit after the rising edge. Everything is
//   sampled on the falling edge.
module tb_oh_gray2bin_pipe;

    typedef struct packed {
        logic [31:0] bin;
        logic        err;
    } exp_t;

    typedef struct {
        logic [3:0] gray;
        logic [3:0] bin;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=4, S=2 instance
    logic       reset4 = 1'b1;
    logic       in_valid4 = 1'b0;
    logic [3:0] in_gray4 = '0;
    logic       in_ready4;
    logic       out_valid4;
    logic [3:0] out_bin4;
    logic       out_err4;
    logic       out_ready4 = 1'b1;
    logic [3:0] exp_bin4 = '0;

    // N=7, S=3 instance
    logic       reset7 = 1'b1;
    logic       in_valid7 = 1'b0;
    logic [6:0] in_gray7 = '0;
    logic       in_ready7;
    logic       out_valid7;
    logic [6:0] out_bin7;
    logic       out_err7;
    logic       out_ready7 = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int acc4     = 0;
    int acc7     = 0;
    int stalls4  = 0;

    exp_t        q4[$];
    exp_t        q7[$];
    logic [31:0] hist4 = '0;
    logic        hist4_v = 1'b0;
    logic [31:0] hist7 = '0;
    logic        hist7_v = 1'b0;

    vec_t tbl[16];

    oh_gray2bin_pipe #(
        .N (4),
        .S (2)
    ) dut4 (
        .clk       (clk),
        .reset     (reset4),
        .in_valid  (in_valid4),
        .in_gray   (in_gray4),
        .in_ready  (in_ready4),
        .out_valid (out_valid4),
        .out_bin   (out_bin4),
        .out_err   (out_err4),
        .out_ready (out_ready4)
    );

    oh_gray2bin_pipe #(
        .N (7),
        .S (3)
    ) dut7 (
        .clk       (clk),
        .reset     (reset7),
        .in_valid  (in_valid7),
        .in_gray   (in_gray7),
        .in_ready  (in_ready7),
        .out_valid (out_valid7),
        .out_bin   (out_bin7),
        .out_err   (out_err7),
        .out_ready (out_ready7)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode: bit i is the XOR of every Gray bit at or above i.
    function automatic logic [31:0] g2b(input logic [31:0] g);
        logic [31:0] b;
        for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic step_model(input logic hv, input logic [31:0] h,
                                        input logic [31:0] g);
        logic en;
`ifdef OH_GRAY2BIN_STEPCHK_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && hv && ($countones(h ^ g) > 1);
    endfunction

    // Scoreboard for dut4.
    always @(negedge clk) begin
        exp_t e;
        if (reset4) begin
            q4.delete();
            hist4_v = 1'b0;
        end else begin
            if (out_valid4 && out_ready4) begin
                if (q4.size() == 0) begin
                    chk("dut4 unexpected output", {28'd0, out_bin4}, 32'hffff_ffff);
                end else begin
                    e = q4.pop_front();
                    chk("dut4 out_bin", {28'd0, out_bin4}, e.bin);
                    chk("dut4 out_err", {31'd0, out_err4}, {31'd0, e.err});
                end
            end
            if (in_valid4 && in_ready4) begin
                e.bin = {28'd0, exp_bin4};
                e.err = step_model(hist4_v, hist4, {28'd0, in_gray4});
                q4.push_back(e);
                hist4   = {28'd0, in_gray4};
                hist4_v = 1'b1;
                acc4++;
            end
        end
    end

    // Scoreboard for dut7.
    always @(negedge clk) begin
        exp_t e;
        if (reset7) begin
            q7.delete();
            hist7_v = 1'b0;
        end else begin
            if (out_valid7 && out_ready7) begin
                if (q7.size() == 0) begin
                    chk("dut7 unexpected output", {25'd0, out_bin7}, 32'hffff_ffff);
                end else begin
                    e = q7.pop_front();
                    chk("dut7 out_bin", {25'd0, out_bin7}, e.bin);
                    chk("dut7 out_err", {31'd0, out_err7}, {31'd0, e.err});
                end
            end
            if (in_valid7 && in_ready7) begin
                e.bin = g2b({25'd0, in_gray7});
                e.err = step_model(hist7_v, hist7, {25'd0, in_gray7});
                q7.push_back(e);
                hist7   = {25'd0, in_gray7};
                hist7_v = 1'b1;
                acc7++;
            end
        end
    end

    // All dut4 tasks start and end 1 time unit after a rising edge.
    task automatic do_reset4();
        reset4    = 1'b1;
        in_valid4 = 1'b0;
        @(negedge clk);
        chk("in_ready low in reset", {31'd0, in_ready4}, 32'd0);
        @(posedge clk); #1;
        reset4 = 1'b0;
        @(negedge clk);
        chk("reset out_valid", {31'd0, out_valid4}, 32'd0);
        chk("reset out_bin", {28'd0, out_bin4}, 32'd0);
        chk("reset out_err", {31'd0, out_err4}, 32'd0);
        chk("in_ready after reset", {31'd0, in_ready4}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send4(input logic [3:0] g, input logic [3:0] b);
        int waited;
        in_valid4 = 1'b1;
        in_gray4  = g;
        exp_bin4  = b;
        waited    = 0;
        @(negedge clk);
        while (!in_ready4 && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready4) chk("dut4 send timeout", 32'd0, 32'd1);
        if (waited > 0) stalls4++;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    task automatic drain4();
        int n;
        n = 0;
        while (q4.size() != 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("dut4 drain", q4.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int n;
        for (int k = 0; k < 16; k++) begin
            tbl[k].gray = 4'(k ^ (k >> 1));
            tbl[k].bin  = 4'(k);
        end

        @(posedge clk); #1;
        do_reset4();

        // Single word, latency check.
        send4(4'b0110, 4'b0100);
        @(negedge clk);
        chk("latency: not yet valid", {31'd0, out_valid4}, 32'd0);
        @(negedge clk);
        chk("latency: valid after S", {31'd0, out_valid4}, 32'd1);
        chk("latency: out_bin", {28'd0, out_bin4}, 32'b0100);
        @(posedge clk); #1;
        drain4();

        // Back-to-back stream of Gray codes 0..15.
        stalls4 = 0;
        for (int k = 0; k < 16; k++) send4(tbl[k].gray, tbl[k].bin);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("stream drained in S cycles", q4.size(), 32'd0);
        chk("stream stalls", stalls4, 32'd0);
        @(posedge clk); #1;

        // Backpressure: two fill the pipe, the third waits.
        out_ready4 = 1'b0;
        snap = acc4;
        send4(tbl[5].gray, tbl[5].bin);
        send4(tbl[9].gray, tbl[9].bin);
        in_valid4 = 1'b1;
        in_gray4  = tbl[12].gray;
        exp_bin4  = tbl[12].bin;
        @(negedge clk);
        chk("full: in_ready low", {31'd0, in_ready4}, 32'd0);
        chk("full: accepted", acc4 - snap, 32'd2);
        chk("full: out_valid", {31'd0, out_valid4}, 32'd1);
        chk("full: out_bin", {28'd0, out_bin4}, 32'd5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall: out_bin held", {28'd0, out_bin4}, 32'd5);
        chk("stall: out_valid held", {31'd0, out_valid4}, 32'd1);
        chk("stall: out_err held", {31'd0, out_err4}, 32'd0);
        @(posedge clk); #1;
        out_ready4 = 1'b1;
        send4(tbl[12].gray, tbl[12].bin);
        drain4();
        chk("backpressure accepted", acc4 - snap, 32'd3);

        // Two-bit step after reset.
        do_reset4();
        send4(4'b0000, 4'b0000);
        send4(4'b0011, 4'b0010);
        drain4();

        // Reset with words in flight.
        out_ready4 = 1'b0;
        send4(tbl[3].gray, tbl[3].bin);
        send4(tbl[6].gray, tbl[6].bin);
        do_reset4();
        out_ready4 = 1'b1;
        send4(4'b0001, 4'b0001);
        drain4();

        // N=7, S=3 random stream with random backpressure.
        @(posedge clk); #1;
        reset7 = 1'b1;
        @(posedge clk); #1;
        reset7 = 1'b0;
        @(negedge clk);
        chk("dut7 reset out_valid", {31'd0, out_valid7}, 32'd0);
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 5000 && acc7 < 300; cyc++) begin
            in_valid7  = ($urandom_range(0, 3) != 0);
            in_gray7   = 7'($urandom);
            out_ready7 = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        in_valid7  = 1'b0;
        out_ready7 = 1'b1;
        n = 0;
        while (q7.size() != 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("dut7 drain", q7.size(), 32'd0);
        chk("dut7 words accepted", {31'd0, acc7 >= 300}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
